dmem_ctrl: RTL and testbench

Parametrised byte-addressed data memory for the pipelined core, with a request/response handshake.
- Supports byte, half and word loads and stores, including sign/zero extension of loads.
- Transparently splits misaligned accesses that cross a word boundary into two beats.
- Flags out-of-range and illegal accesses.
- Sits between the MEM stage and the word-organised RAM bank; replaces the old combinational-read data memory.

---
 rtl/dmem_pkg.sv | 34 +++
 rtl/dmem_bank.sv | 33 +++
 rtl/dmem_ctrl.sv | 163 ++++++++++++++++
 tb/tb_dmem_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared encodings and helpers for the byte-addressed data memory controller.
package dmem_pkg;

   // Access size encodings (funct3[1:0]); 2'd3 is illegal.
   localparam logic [1:0] SZ_B = 2'd0;
   localparam logic [1:0] SZ_H = 2'd1;
   localparam logic [1:0] SZ_W = 2'd2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BEAT2 = 2'd1,
      RESP  = 2'd2
   } state_t;

   // Byte-enable pattern for a lane-0 access of the given size.
   function automatic logic [3:0] byte_mask(input logic [1:0] size);
      case (size)
         SZ_B:    return 4'b0001;
         SZ_H:    return 4'b0011;
         SZ_W:    return 4'b1111;
         default: return 4'b0000;
      endcase
   endfunction

   // Offset from the first to the last byte touched by an access.
   function automatic logic [1:0] last_offset(input logic [1:0] size);
      case (size)
         SZ_B:    return 2'd0;
         SZ_H:    return 2'd1;
         default: return 2'd3;
      endcase
   endfunction

endpackage

// File: rtl/dmem_bank.sv
// 1R1W word RAM with synchronous read and per-byte write enables.
// A read and write to the same word in one cycle returns the old data.
module dmem_bank #(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter string       INIT_FILE   = "",
   parameter int unsigned AW          = $clog2(DEPTH_WORDS)
) (
   input  logic          clk,
   input  logic          re,
   input  logic          we,
   input  logic [AW-1:0] addr,
   input  logic [3:0]    wbe,
   input  logic [31:0]   wdata,
   output logic [31:0]   rdata
);

   logic [31:0] mem [DEPTH_WORDS];

   // Byte-masked write; contents are deliberately never reset.
   always_ff @(posedge clk) begin
      if (we) begin
         for (int b = 0; b < 4; b++) begin
            if (wbe[b]) mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
         end
      end
   end

   // Registered read; output holds between read enables.
   always_ff @(posedge clk) begin
      if (re) rdata <= mem[addr];
   end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller for the MEM stage: byte/half/word loads and stores
// with valid/ready handshake, two-beat split of word-crossing accesses and
// fault reporting for illegal size, out-of-range or disallowed misalignment.
module dmem_ctrl
   import dmem_pkg::*;
#(
   parameter int unsigned ADDR_W      = 32,
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter bit          MISALIGN_EN = 1'b1,
   parameter string       INIT_FILE   = ""
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [31:0]       rsp_rdata,
   output logic              rsp_err
);

   localparam int unsigned     WAW   = $clog2(DEPTH_WORDS);
   localparam logic [ADDR_W:0] LIMIT = (ADDR_W + 1)'(DEPTH_WORDS * 4);
   localparam logic [WAW-1:0]  ONE   = WAW'(1);

   state_t         state;
   logic           rsp_valid_q, err_q, we_q, uns_q, cross_q;
   logic [1:0]     size_q, lane_q;
   logic [31:0]    wdata_q, lo_q;
   logic [WAW-1:0] word_q;

   logic           accept, req_cross, req_err, in_beat2;
   logic [1:0]     req_lane;
   logic [ADDR_W:0] last_addr;
   logic [1:0]     sel_size, sel_lane;
   logic [31:0]    sel_data;
   logic [7:0]     be_full;
   logic [63:0]    wd_full;
   logic           bank_re, bank_we;
   logic [WAW-1:0] bank_addr;
   logic [3:0]     bank_be;
   logic [31:0]    bank_wd, bank_rdata;
   logic [31:0]    lo_word, shifted, ext;

   // Request decode: crossing detection, fault checks and handshake.
   always_comb begin
      req_lane  = req_addr[1:0];
      req_cross = ((req_size == SZ_H) && (req_lane == 2'd3)) ||
                  ((req_size == SZ_W) && (req_lane != 2'd0));
      last_addr = {1'b0, req_addr} + (ADDR_W + 1)'(last_offset(req_size));
      req_err   = (req_size == 2'd3) || (last_addr >= LIMIT) ||
                  (req_cross && !MISALIGN_EN);
      // RESP counts as free when its response leaves this same cycle.
      req_ready = rstn && (state != BEAT2) && !(rsp_valid_q && !rsp_ready);
      accept    = req_valid && req_ready;
   end

   // Bank port steering: first beat from the live request, second from saved state.
   always_comb begin
      in_beat2  = (state == BEAT2);
      sel_size  = in_beat2 ? size_q  : req_size;
      sel_lane  = in_beat2 ? lane_q  : req_lane;
      sel_data  = in_beat2 ? wdata_q : req_wdata;
      be_full   = {4'b0000, byte_mask(sel_size)} << sel_lane;
      wd_full   = {32'h0, sel_data} << {sel_lane, 3'b000};
      bank_we   = in_beat2 ? we_q  : (accept && req_we && !req_err);
      bank_re   = in_beat2 ? !we_q : (accept && !req_we && !req_err);
      bank_be   = in_beat2 ? be_full[7:4]  : be_full[3:0];
      bank_wd   = in_beat2 ? wd_full[63:32] : wd_full[31:0];
      bank_addr = in_beat2 ? word_q + ONE : req_addr[WAW+1:2];
   end

   dmem_bank #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .INIT_FILE   (INIT_FILE),
      .AW          (WAW)
   ) u_bank (
      .clk   (clk),
      .re    (bank_re),
      .we    (bank_we),
      .addr  (bank_addr),
      .wbe   (bank_be),
      .wdata (bank_wd),
      .rdata (bank_rdata)
   );

   // Load extraction from {upper, lower} word pair; zero outside a good load.
   always_comb begin
      lo_word = cross_q ? lo_q : bank_rdata;
      shifted = 32'({bank_rdata, lo_word} >> {lane_q, 3'b000});
      case (size_q)
         SZ_B:    ext = uns_q ? {24'h0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
         SZ_H:    ext = uns_q ? {16'h0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
         default: ext = shifted;
      endcase
      rsp_rdata = (rsp_valid_q && !err_q && !we_q) ? ext : 32'h0;
      rsp_valid = rsp_valid_q;
      rsp_err   = err_q;
   end

   // Controller FSM with registered response flags and captured request.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state       <= IDLE;
         rsp_valid_q <= 1'b0;
         err_q       <= 1'b0;
         we_q        <= 1'b0;
         uns_q       <= 1'b0;
         cross_q     <= 1'b0;
         size_q      <= SZ_B;
         lane_q      <= 2'd0;
         wdata_q     <= 32'h0;
         lo_q        <= 32'h0;
         word_q      <= '0;
      end else if (accept) begin
         we_q    <= req_we;
         uns_q   <= req_unsigned;
         size_q  <= req_size;
         lane_q  <= req_lane;
         wdata_q <= req_wdata;
         word_q  <= req_addr[WAW+1:2];
         if (req_err) begin
            state       <= RESP;
            rsp_valid_q <= 1'b1;
            err_q       <= 1'b1;
            cross_q     <= 1'b0;
         end else if (req_cross) begin
            state       <= BEAT2;
            rsp_valid_q <= 1'b0;
            err_q       <= 1'b0;
            cross_q     <= 1'b1;
         end else begin
            state       <= RESP;
            rsp_valid_q <= 1'b1;
            err_q       <= 1'b0;
            cross_q     <= 1'b0;
         end
      end else begin
         case (state)
            BEAT2: begin
               // Bank output still holds the lower word read in the first beat.
               lo_q        <= bank_rdata;
               state       <= RESP;
               rsp_valid_q <= 1'b1;
            end
            RESP: begin
               if (rsp_ready) begin
                  state       <= IDLE;
                  rsp_valid_q <= 1'b0;
                  err_q       <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl: one misalign-capable instance and one that
// faults on misalignment, with expected responses queued at acceptance.
module tb_dmem_ctrl;
   import dmem_pkg::*;

   localparam int unsigned DW = 64;

   typedef struct packed {
      logic [31:0] d;
      logic        e;
   } exp_t;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        req_valid = 1'b0, req_we = 1'b0, req_unsigned = 1'b0, rsp_ready = 1'b1;
   logic [1:0]  req_size = 2'd0;
   logic [31:0] req_addr = 32'h0, req_wdata = 32'h0;
   logic        sel = 1'b0;

   logic        valid_a, valid_b;
   logic        rdy_a, rdy_b, vld_a, vld_b, err_a, err_b;
   logic [31:0] rd_a, rd_b;
   logic        m_rdy, m_vld, m_err;
   logic [31:0] m_rd;

   exp_t sb[$];
   int   n_vec = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;

   assign valid_a = req_valid && !sel;
   assign valid_b = req_valid && sel;
   assign m_rdy   = sel ? rdy_b : rdy_a;
   assign m_vld   = sel ? vld_b : vld_a;
   assign m_err   = sel ? err_b : err_a;
   assign m_rd    = sel ? rd_b : rd_a;

   dmem_ctrl #(
      .ADDR_W      (32),
      .DEPTH_WORDS (DW),
      .MISALIGN_EN (1'b1),
      .INIT_FILE   ("")
   ) u_dut_a (
      .clk          (clk),
      .rstn         (rstn),
      .req_valid    (valid_a),
      .req_ready    (rdy_a),
      .req_we       (req_we),
      .req_size     (req_size),
      .req_unsigned (req_unsigned),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .rsp_valid    (vld_a),
      .rsp_ready    (rsp_ready),
      .rsp_rdata    (rd_a),
      .rsp_err      (err_a)
   );

   dmem_ctrl #(
      .ADDR_W      (32),
      .DEPTH_WORDS (DW),
      .MISALIGN_EN (1'b0),
      .INIT_FILE   ("")
   ) u_dut_b (
      .clk          (clk),
      .rstn         (rstn),
      .req_valid    (valid_b),
      .req_ready    (rdy_b),
      .req_we       (req_we),
      .req_size     (req_size),
      .req_unsigned (req_unsigned),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .rsp_valid    (vld_b),
      .rsp_ready    (rsp_ready),
      .rsp_rdata    (rd_b),
      .rsp_err      (err_b)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One request through the selected instance, rsp_ready held high.
   task automatic txn(input string tag, input logic we, input logic [1:0] size,
                      input logic uns, input logic [31:0] addr, input logic [31:0] wd,
                      input logic [31:0] exp_d, input logic exp_e, input int exp_lat);
      int   n;
      int   lat;
      exp_t e;
      @(negedge clk);
      req_we       = we;
      req_size     = size;
      req_unsigned = uns;
      req_addr     = addr;
      req_wdata    = wd;
      req_valid    = 1'b1;
      n = 0;
      while (!m_rdy && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "/ready"}, 32'(m_rdy), 32'd1);
      if (!m_rdy) begin
         req_valid = 1'b0;
         return;
      end
      @(posedge clk);
      sb.push_back('{d: exp_d, e: exp_e});
      #1 req_valid = 1'b0;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!m_vld && lat < 10);
      chk({tag, "/latency"}, 32'(lat), 32'(exp_lat));
      e = sb.pop_front();
      chk({tag, "/rdata"}, m_rd, e.d);
      chk({tag, "/err"}, 32'(m_err), 32'(e.e));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      exp_t e;

      // Reset state
      #12;
      chk("rst/valid", 32'(vld_a), 32'd0);
      chk("rst/rdata", rd_a, 32'h0);
      chk("rst/err", 32'(err_a), 32'd0);
      chk("rst/ready_a", 32'(rdy_a), 32'd0);
      chk("rst/ready_b", 32'(rdy_b), 32'd0);
      @(negedge clk);
      rstn = 1'b1;
      #1 chk("post_rst/ready", 32'(rdy_a), 32'd1);

      // Aligned word and sub-word accesses
      sel = 1'b0;
      txn("sw10", 1'b1, SZ_W, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 1);
      txn("lw10", 1'b0, SZ_W, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 1);
      txn("lb13", 1'b0, SZ_B, 1'b0, 32'h13, 32'h0, 32'hFFFFFFDE, 1'b0, 1);
      txn("lbu13", 1'b0, SZ_B, 1'b1, 32'h13, 32'h0, 32'h000000DE, 1'b0, 1);
      txn("lh12", 1'b0, SZ_H, 1'b0, 32'h12, 32'h0, 32'hFFFFDEAD, 1'b0, 1);
      txn("lhu10", 1'b0, SZ_H, 1'b1, 32'h10, 32'h0, 32'h0000BEEF, 1'b0, 1);

      // Word-crossing store and loads
      txn("sw20z", 1'b1, SZ_W, 1'b0, 32'h20, 32'h0, 32'h0, 1'b0, 1);
      txn("sw24z", 1'b1, SZ_W, 1'b0, 32'h24, 32'h0, 32'h0, 1'b0, 1);
      txn("sw22", 1'b1, SZ_W, 1'b0, 32'h22, 32'h11223344, 32'h0, 1'b0, 2);
      txn("lw20", 1'b0, SZ_W, 1'b0, 32'h20, 32'h0, 32'h33440000, 1'b0, 1);
      txn("lw24", 1'b0, SZ_W, 1'b0, 32'h24, 32'h0, 32'h00001122, 1'b0, 1);
      txn("lw22", 1'b0, SZ_W, 1'b0, 32'h22, 32'h0, 32'h11223344, 1'b0, 2);
      txn("lh23", 1'b0, SZ_H, 1'b0, 32'h23, 32'h0, 32'h00002233, 1'b0, 2);

      // Faults
      txn("lw_oor", 1'b0, SZ_W, 1'b0, DW * 4, 32'h0, 32'h0, 1'b1, 1);
      txn("lw_edge", 1'b0, SZ_W, 1'b0, DW * 4 - 2, 32'h0, 32'h0, 1'b1, 1);
      txn("size3", 1'b0, 2'd3, 1'b0, 32'h10, 32'h0, 32'h0, 1'b1, 1);
      txn("lw10_again", 1'b0, SZ_W, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 1);

      // Backpressure, then same-cycle accept on release
      @(negedge clk);
      rsp_ready    = 1'b0;
      req_we       = 1'b0;
      req_size     = SZ_W;
      req_unsigned = 1'b0;
      req_addr     = 32'h10;
      req_valid    = 1'b1;
      @(posedge clk);
      sb.push_back('{d: 32'hDEADBEEF, e: 1'b0});
      #1;
      req_size = SZ_B;
      req_addr = 32'h13;
      e = sb.pop_front();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("bp/valid", 32'(vld_a), 32'd1);
         chk("bp/rdata", rd_a, e.d);
         chk("bp/ready", 32'(rdy_a), 32'd0);
      end
      rsp_ready = 1'b1;
      #1 chk("bp/release_ready", 32'(rdy_a), 32'd1);
      @(posedge clk);
      sb.push_back('{d: 32'hFFFFFFDE, e: 1'b0});
      #1 req_valid = 1'b0;
      @(negedge clk);
      chk("bp/next_valid", 32'(vld_a), 32'd1);
      e = sb.pop_front();
      chk("bp/next_rdata", rd_a, e.d);

      // Misalignment disabled: fault and no write
      sel = 1'b1;
      txn("b_sw20", 1'b1, SZ_W, 1'b0, 32'h20, 32'hAABBCCDD, 32'h0, 1'b0, 1);
      txn("b_sw24", 1'b1, SZ_W, 1'b0, 32'h24, 32'h55667788, 32'h0, 1'b0, 1);
      txn("b_lw22", 1'b0, SZ_W, 1'b0, 32'h22, 32'h0, 32'h0, 1'b1, 1);
      txn("b_sw22", 1'b1, SZ_W, 1'b0, 32'h22, 32'h12345678, 32'h0, 1'b1, 1);
      txn("b_lw20", 1'b0, SZ_W, 1'b0, 32'h20, 32'h0, 32'hAABBCCDD, 1'b0, 1);
      txn("b_lw24", 1'b0, SZ_W, 1'b0, 32'h24, 32'h0, 32'h55667788, 1'b0, 1);

      // Reset during the second beat of a crossing store
      sel = 1'b0;
      txn("sw30z", 1'b1, SZ_W, 1'b0, 32'h30, 32'h0, 32'h0, 1'b0, 1);
      txn("sw34z", 1'b1, SZ_W, 1'b0, 32'h34, 32'h0, 32'h0, 1'b0, 1);
      @(negedge clk);
      req_we    = 1'b1;
      req_size  = SZ_W;
      req_addr  = 32'h31;
      req_wdata = 32'hCAFEF00D;
      req_valid = 1'b1;
      @(posedge clk);
      #1 req_valid = 1'b0;
      chk("mid/beat2_valid", 32'(vld_a), 32'd0);
      #1 rstn = 1'b0;
      #1;
      chk("mid/rst_valid", 32'(vld_a), 32'd0);
      chk("mid/rst_ready", 32'(rdy_a), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rstn = 1'b1;
      #1 chk("mid/resume_ready", 32'(rdy_a), 32'd1);
      txn("mid/lw30", 1'b0, SZ_W, 1'b0, 32'h30, 32'h0, 32'hFEF00D00, 1'b0, 1);
      txn("mid/lw34", 1'b0, SZ_W, 1'b0, 32'h34, 32'h0, 32'h00000000, 1'b0, 1);

      @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
